assignment_2: RTL and testbench

- Parameterisable ripple-carry adder built from full-adder cells. With the default WIDTH=1 it is a single-bit full adder.
- Provides combinational Sum/Cout outputs, plus a registered copy of the result captured on an enable.
- Used as the basic arithmetic cell in lab datapaths. The combinational path is usable without a running clock.

---
 rtl/assignment_2.sv | 71 +++++++
 tb/tb_assignment_2.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/assignment_2.sv
// assignment_2: WIDTH-bit ripple-carry adder built from full-adder cells.
// Combinational Sum/Cout plus a registered copy captured on en.
// Optional build macro: CARRY_COUNT_EN adds a saturating 16-bit carry-out counter.
module assignment_2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             en,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             valid_q
`ifdef CARRY_COUNT_EN
  ,
  output logic [15:0]      carry_cnt
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  // Chain of full-adder cells; carry ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
  end

  assign Sum  = s;
  assign Cout = c[WIDTH];

  // Capture register: sync reset wins over en; valid pulses for one cycle per capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      sum_q   <= Sum;
      cout_q  <= Cout;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

`ifdef CARRY_COUNT_EN
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  // Count enabled carry-outs, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && Cout && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign carry_cnt = cnt;
`endif

endmodule

// File: tb/tb_assignment_2.sv
// Directed self-checking bench for assignment_2 at WIDTH=1 and WIDTH=8.
// Exercises the carry counter only when built with CARRY_COUNT_EN.
module tb_assignment_2;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       en;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sum_q1, cout_q1, valid_q1;

  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8, sum_q8;
  logic       cout8, cout_q8, valid_q8;

`ifdef CARRY_COUNT_EN
  logic [15:0] cnt1, cnt8;
`endif

  int errors = 0;
  int checks = 0;

  // Expected {Cout,Sum} for {A,B,Cin} = 0..7
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  assignment_2 #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .en(en),
    .Sum(sum1), .Cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .valid_q(valid_q1)
`ifdef CARRY_COUNT_EN
    , .carry_cnt(cnt1)
`endif
  );

  assignment_2 #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .en(en),
    .Sum(sum8), .Cout(cout8), .sum_q(sum_q8), .cout_q(cout_q8), .valid_q(valid_q8)
`ifdef CARRY_COUNT_EN
    , .carry_cnt(cnt8)
`endif
  );

  // Clock held low until the combinational-only phase is over
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; clk_run = 1'b0; rst_n = 1'b0; en = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

    // Full truth table, no clock running
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, cin1} = v;
      #10;
      check($sformatf("tt_%0d", i), 32'({cout1, sum1}), 32'(tt[i]));
    end

    // WIDTH=8 combinational vectors
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; #10;
    check("w8_ff_01", 32'({cout8, sum8}), 32'h100);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #10;
    check("w8_ff_ff_1", 32'({cout8, sum8}), 32'h1FF);
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; #10;
    check("w8_5a_33_1", 32'({cout8, sum8}), 32'h08E);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; #10;
    check("w8_80_80", 32'({cout8, sum8}), 32'h100);

    // Reset for two edges
    clk_run = 1'b1;
    rst_n = 1'b0; en = 1'b1;
    tick(); tick();
    check("rst_w1", 32'({cout_q1, sum_q1, valid_q1}), 32'h0);
    check("rst_w8", 32'({cout_q8, sum_q8, valid_q8}), 32'h0);

    // Capture 1+1+0
    rst_n = 1'b1; en = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    tick();
    check("cap_w1", 32'({sum_q1, cout_q1, valid_q1}), 32'b011);
    check("cap_w8", 32'({cout_q8, sum_q8, valid_q8}), 32'h201);

    // Hold with en=0 while inputs change
    en = 1'b0; a1 = 1'b0; b1 = 1'b1;
    a8 = 8'h12; b8 = 8'h34;
    tick();
    check("hold_w1", 32'({sum_q1, cout_q1, valid_q1}), 32'b010);
    check("hold_w8", 32'({cout_q8, sum_q8, valid_q8}), 32'h200);
    check("hold_comb_w1", 32'({cout1, sum1}), 32'b01);
    check("hold_comb_w8", 32'({cout8, sum8}), 32'h046);

    // Capture sum_q=1, then reset mid-operation with en=1
    en = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1;
    tick();
    check("cap2_w1", 32'({sum_q1, cout_q1, valid_q1}), 32'b101);
    check("cap2_w8", 32'({cout_q8, sum_q8, valid_q8}), 32'h11D);
    rst_n = 1'b0;
    tick();
    check("midrst_w1", 32'({sum_q1, cout_q1, valid_q1}), 32'b000);
    check("midrst_w8", 32'({cout_q8, sum_q8, valid_q8}), 32'h0);
    check("midrst_comb_w1", 32'({cout1, sum1}), 32'b01);
    check("midrst_comb_w8", 32'({cout8, sum8}), 32'h08E);

`ifdef CARRY_COUNT_EN
    check("cnt_rst", 32'(cnt1), 32'h0);
    rst_n = 1'b1; en = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    repeat (5) tick();
    check("cnt_5", 32'(cnt1), 32'd5);
    check("cnt_w8_nocarry", 32'(cnt8), 32'd0);
    en = 1'b0;
    tick();
    check("cnt_en0", 32'(cnt1), 32'd5);
    en = 1'b1; b1 = 1'b0;
    tick();
    check("cnt_nocarry", 32'(cnt1), 32'd5);
    b1 = 1'b1;
    repeat (65530) tick();
    check("cnt_max", 32'(cnt1), 32'hFFFF);
    repeat (3) tick();
    check("cnt_sat", 32'(cnt1), 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
